// File: rtl/iecdrv_burst_pkg.sv
// Shared types and constants for the IEC fast-serial burst transceiver.
// The optional slave watchdog is enabled by defining IECDRV_BURST_TIMEOUT_EN.
package iecdrv_burst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH,
    DONE
  } state_e;

  localparam int TIMEOUT_LIMIT = 4095;

  // One extra pointer bit separates "full" from "empty" when the indices match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/iecdrv_burst_fifo.sv
// First-word-fall-through FIFO with wrapping extra-bit pointers; used for TX and RX.
module iecdrv_burst_fifo
  import iecdrv_burst_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count == PW'(DEPTH));
  assign empty_o = (count == '0);

  // Full/empty are judged on the count before this cycle's operations.
  assign push_ok = push_i && !full_o && !clr_i;
  assign pop_ok  = pop_i && !empty_o && !clr_i;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/iecdrv_burst_ser.sv
// Fast-serial (burst) transceiver: master shifts TX frames out on fclk/data,
// slave samples them into RX. Define IECDRV_BURST_TIMEOUT_EN for the slave watchdog.
module iecdrv_burst_ser
  import iecdrv_burst_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DIV   = 4,
  parameter int SYNC  = 2
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             ce,
  input  logic             master,
  input  logic             fclk_i,
  input  logic             data_i,
  input  logic             atn_i,
  output logic             fclk_o,
  output logic             data_o,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             ovf,
  output logic             abort,
  input  logic             clr
);

  localparam int              BW       = $clog2(WIDTH);
  localparam logic [7:0]      DIV_LAST = 8'(DIV - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);

  logic [SYNC-1:0] fclk_sync_q;
  logic [SYNC-1:0] data_sync_q;
  logic [SYNC-1:0] atn_sync_q;
  logic            fclk_prev_q;
  logic            atn_prev_q;
  logic            fclk_s;
  logic            data_s;
  logic            atn_s;
  logic            fclk_rise;
  logic            atn_fall;

  logic             tx_full;
  logic             tx_empty;
  logic             tx_pop;
  logic [WIDTH-1:0] tx_head;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_push;
  logic [WIDTH-1:0] rx_frame;

  state_e           state_q;
  logic [7:0]       div_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] tx_shift_q;
  logic             fclk_o_q;
  logic             data_o_q;
  logic             mst_stop;

  logic [BW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic             ovf_q, ovf_d;
  logic             abort_q;
  logic             busy_int;
  logic             wd_fire;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      fclk_sync_q <= '1;
      data_sync_q <= '1;
      atn_sync_q  <= '1;
      fclk_prev_q <= 1'b1;
      atn_prev_q  <= 1'b1;
    end else begin
      fclk_sync_q <= {fclk_sync_q[SYNC-2:0], fclk_i};
      data_sync_q <= {data_sync_q[SYNC-2:0], data_i};
      atn_sync_q  <= {atn_sync_q[SYNC-2:0], atn_i};
      fclk_prev_q <= fclk_s;
      atn_prev_q  <= atn_s;
    end
  end

  assign fclk_s    = fclk_sync_q[SYNC-1];
  assign data_s    = data_sync_q[SYNC-1];
  assign atn_s     = atn_sync_q[SYNC-1];
  assign fclk_rise = fclk_s && !fclk_prev_q;
  assign atn_fall  = !atn_s && atn_prev_q;

  iecdrv_burst_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .res_n   (res_n),
    .clr_i   (clr),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .full_o  (tx_full),
    .pop_i   (tx_pop),
    .empty_o (tx_empty),
    .rdata_o (tx_head)
  );

  iecdrv_burst_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .res_n   (res_n),
    .clr_i   (clr),
    .push_i  (rx_push),
    .wdata_i (rx_frame),
    .full_o  (rx_full),
    .pop_i   (rx_ready),
    .empty_o (rx_empty),
    .rdata_o (rx_data)
  );

  assign busy_int = (state_q != IDLE) || (rx_cnt_q != '0);

  // Leaving master mode or ATN mid-frame both drop the frame and free the lines.
  assign mst_stop = !master || (atn_fall && (state_q != IDLE));
  assign tx_pop   = ce && master && (state_q == IDLE) && !tx_empty;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_shift_q <= '0;
      fclk_o_q   <= 1'b1;
      data_o_q   <= 1'b1;
    end else if (mst_stop) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      fclk_o_q <= 1'b1;
      data_o_q <= 1'b1;
    end else if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (!tx_empty) begin
            tx_shift_q <= tx_head;
            div_q      <= '0;
            bit_q      <= '0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          data_o_q <= tx_shift_q[WIDTH-1];
          fclk_o_q <= 1'b0;
          state_q  <= LOW;
        end
        LOW: begin
          if (div_q == DIV_LAST) begin
            div_q    <= '0;
            fclk_o_q <= 1'b1;
            state_q  <= HIGH;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        HIGH: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bit_q != BIT_LAST) begin
              bit_q      <= bit_q + 1'b1;
              tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
              data_o_q   <= tx_shift_q[WIDTH-2];
              fclk_o_q   <= 1'b0;
              state_q    <= LOW;
            end else begin
              state_q <= DONE;
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        DONE: begin
          data_o_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_frame = {rx_shift_q[WIDTH-2:0], data_s};

  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    ovf_d      = ovf_q;
    rx_push    = 1'b0;
    if (master || (atn_fall && (rx_cnt_q != '0)) || wd_fire) begin
      rx_cnt_d = '0;
    end else if (fclk_rise) begin
      rx_shift_d = rx_frame;
      if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        rx_push  = 1'b1;
        if (rx_full) ovf_d = 1'b1;
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
    end
    if (clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      ovf_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      ovf_q      <= ovf_d;
      abort_q    <= (atn_fall && busy_int) || wd_fire;
    end
  end

`ifdef IECDRV_BURST_TIMEOUT_EN
  logic [11:0] wd_q, wd_d;

  // Counts ce while a slave frame is partially received; any fclk rise restarts it.
  always_comb begin
    wd_d    = wd_q;
    wd_fire = 1'b0;
    if (master || (rx_cnt_q == '0) || fclk_rise) begin
      wd_d = '0;
    end else if (ce) begin
      if (wd_q == 12'(TIMEOUT_LIMIT - 1)) begin
        wd_fire = 1'b1;
        wd_d    = '0;
      end else begin
        wd_d = wd_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign fclk_o   = fclk_o_q;
  assign data_o   = data_o_q;
  assign busy     = busy_int;
  assign ovf      = ovf_q;
  assign abort    = abort_q;
  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

endmodule
